// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory bus arbiter: owner states, MMIO map, burst default.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  // MMIO window shared with the memory and the program loader
  localparam logic [31:0] MMIO_DISPLAY  = 32'hC000_0000;
  localparam logic [31:0] MMIO_BUTTON   = 32'hC000_0004;
  localparam logic [31:0] MMIO_SWITCHES = 32'hC000_0008;

  localparam int unsigned DEFAULT_MAX_BURST = 8;
  localparam int unsigned STAT_W            = 16;

endpackage

// File: rtl/mem_bus_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module arb_sat_counter #(
  parameter int unsigned  W   = 8,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != MAX)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-requester round-robin arbiter for the unified memory port with bounded bursts.
// Optional grant/wait statistics are built when ARB_STATS_EN is defined.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_BURST = DEFAULT_MAX_BURST
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] a0,
  input  logic [ADDR_W-1:0] a1,
  input  logic [DATA_W-1:0] wd0,
  input  logic [DATA_W-1:0] wd1,
  input  logic              we0,
  input  logic              we1,
  output logic              gnt0,
  output logic              gnt1,
  output logic [DATA_W-1:0] rd0,
  output logic [DATA_W-1:0] rd1,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_wd,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rd,
  output logic [STAT_W-1:0] stat_gnt0,
  output logic [STAT_W-1:0] stat_gnt1,
  output logic [STAT_W-1:0] stat_wait1
);

  localparam int unsigned      CNT_W      = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

  arb_state_t       state, state_nxt;
  logic             last, last_nxt;
  logic [CNT_W-1:0] burst_cnt;
  logic             cnt_clear, cnt_inc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (req0 && req1) state_nxt = last ? OWN0 : OWN1;
        else if (req0)    state_nxt = OWN0;
        else if (req1)    state_nxt = OWN1;
      end
      OWN0: begin
        if (req0) begin
          if (req1 && (burst_cnt == BURST_LAST)) state_nxt = OWN1;
        end else if (req1) begin
          state_nxt = OWN1;
        end else begin
          state_nxt = IDLE;
        end
      end
      OWN1: begin
        if (req1) begin
          if (req0 && (burst_cnt == BURST_LAST)) state_nxt = OWN0;
        end else if (req0) begin
          state_nxt = OWN0;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (state_nxt != state) begin
      if (state_nxt == OWN0)      last_nxt = 1'b0;
      else if (state_nxt == OWN1) last_nxt = 1'b1;
    end
  end

  // Any state change restarts the burst; staying in an OWN state counts up to BURST_LAST.
  assign cnt_clear = reset || (state_nxt != state);
  assign cnt_inc   = (state != IDLE);

  arb_sat_counter #(
    .W   (CNT_W),
    .MAX (BURST_LAST)
  ) u_burst_cnt (
    .clk   (clk),
    .clear (cnt_clear),
    .inc   (cnt_inc),
    .count (burst_cnt)
  );

  always_comb begin
    gnt0   = (state == OWN0) && req0;
    gnt1   = (state == OWN1) && req1;
    mem_a  = '0;
    mem_wd = '0;
    mem_we = 1'b0;
    if (gnt0) begin
      mem_a  = a0;
      mem_wd = wd0;
      mem_we = we0;
    end else if (gnt1) begin
      mem_a  = a1;
      mem_wd = wd1;
      mem_we = we1;
    end
    rd0 = gnt0 ? mem_rd : '0;
    rd1 = gnt1 ? mem_rd : '0;
  end

`ifdef ARB_STATS_EN
  arb_sat_counter #(.W(STAT_W)) u_stat_gnt0 (
    .clk   (clk),
    .clear (reset),
    .inc   (gnt0),
    .count (stat_gnt0)
  );

  arb_sat_counter #(.W(STAT_W)) u_stat_gnt1 (
    .clk   (clk),
    .clear (reset),
    .inc   (gnt1),
    .count (stat_gnt1)
  );

  arb_sat_counter #(.W(STAT_W)) u_stat_wait1 (
    .clk   (clk),
    .clear (reset),
    .inc   (req1 && !gnt1),
    .count (stat_wait1)
  );
`else
  assign stat_gnt0  = '0;
  assign stat_gnt1  = '0;
  assign stat_wait1 = '0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomised self-checking bench for mem_bus_arbiter against an ownership/run-length model.
module tb_mem_bus_arbiter;
  import mem_arb_pkg::*;

  localparam int MB = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [31:0] a0, a1, wd0, wd1;
  logic        gnt0, gnt1, mem_we;
  logic [31:0] rd0, rd1, mem_a, mem_wd, mem_rd;
  logic [15:0] stat_gnt0, stat_gnt1, stat_wait1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .MAX_BURST (MB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req0       (req0),
    .req1       (req1),
    .a0         (a0),
    .a1         (a1),
    .wd0        (wd0),
    .wd1        (wd1),
    .we0        (we0),
    .we1        (we1),
    .gnt0       (gnt0),
    .gnt1       (gnt1),
    .rd0        (rd0),
    .rd1        (rd1),
    .mem_a      (mem_a),
    .mem_wd     (mem_wd),
    .mem_we     (mem_we),
    .mem_rd     (mem_rd),
    .stat_gnt0  (stat_gnt0),
    .stat_gnt1  (stat_gnt1),
    .stat_wait1 (stat_wait1)
  );

  // Memory stub: combinational read, clocked write, switches readable, MMIO writes dropped
  logic [31:0] mem_arr [256] = '{default: '0};
  logic [7:0]  sw;

  assign mem_rd = (mem_a == MMIO_SWITCHES) ? {24'h0, sw} : mem_arr[mem_a[9:2]];

  always @(posedge clk) begin
    if (mem_we && !(mem_a inside {MMIO_DISPLAY, MMIO_BUTTON, MMIO_SWITCHES}))
      mem_arr[mem_a[9:2]] <= mem_wd;
  end

  // Reference model: who owns the port, how long it has held it, who went last
  int          m_owner = -1;
  int          m_run   = 0;
  int          m_last  = 1;
  int          m_sg0 = 0, m_sg1 = 0, m_sw1 = 0;
  logic [31:0] ref_mem [256] = '{default: '0};

  logic        e_g0, e_g1, e_we;
  logic [31:0] e_a, e_wd, e_rd0, e_rd1;

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    if (a == MMIO_SWITCHES) return {24'h0, sw};
    return ref_mem[a[9:2]];
  endfunction

  task automatic predict();
    e_g0  = (m_owner == 0) && req0;
    e_g1  = (m_owner == 1) && req1;
    e_a   = e_g0 ? a0 : (e_g1 ? a1 : 32'h0);
    e_wd  = e_g0 ? wd0 : (e_g1 ? wd1 : 32'h0);
    e_we  = (e_g0 && we0) || (e_g1 && we1);
    e_rd0 = e_g0 ? ref_read(a0) : 32'h0;
    e_rd1 = e_g1 ? ref_read(a1) : 32'h0;
  endtask

  task automatic take(input int k);
    m_owner = k;
    m_last  = k;
    m_run   = 0;
  endtask

  task automatic model_edge();
    bit mine, other;
    predict();
    if (e_we && !(e_a inside {MMIO_DISPLAY, MMIO_BUTTON, MMIO_SWITCHES}))
      ref_mem[e_a[9:2]] = e_wd;
    if (reset) begin
      m_owner = -1; m_run = 0; m_last = 1;
      m_sg0 = 0; m_sg1 = 0; m_sw1 = 0;
      return;
    end
    if (e_g0 && m_sg0 < 65535) m_sg0++;
    if (e_g1 && m_sg1 < 65535) m_sg1++;
    if (req1 && !e_g1 && m_sw1 < 65535) m_sw1++;
    if (m_owner < 0) begin
      if (req0 && req1) take(1 - m_last);
      else if (req0)    take(0);
      else if (req1)    take(1);
    end else begin
      mine  = (m_owner == 0) ? req0 : req1;
      other = (m_owner == 0) ? req1 : req0;
      if (mine && other && (m_run + 1 >= MB)) take(1 - m_owner);
      else if (mine)                          m_run++;
      else if (other)                         take(1 - m_owner);
      else                                    m_owner = -1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req0 = 1'b1; req1 = 1'b1;
    a0 = 32'h20; a1 = 32'h24; wd0 = 32'h1; wd1 = 32'h2; we0 = 1'b0; we1 = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    checks++;
    if ({gnt0, gnt1, mem_we, mem_a, mem_wd} !== {1'b0, 1'b0, 1'b0, 32'h0, 32'h0})
      $display("FAIL reset_idle: got g0=%b g1=%b we=%b a=%h wd=%h expected all zero",
               gnt0, gnt1, mem_we, mem_a, mem_wd);
    if ({gnt0, gnt1, mem_we, mem_a, mem_wd} !== {1'b0, 1'b0, 1'b0, 32'h0, 32'h0}) failures++;
    checks++;
    if ({stat_gnt0, stat_gnt1, stat_wait1} !== 48'h0) begin
      failures++;
      $display("FAIL reset_stats: got %h %h %h expected 0", stat_gnt0, stat_gnt1, stat_wait1);
    end
    reset = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if ({gnt0, gnt1} !== 2'b10) begin
      failures++;
      $display("FAIL first_owner: got g0=%b g1=%b expected g0=1 g1=0", gnt0, gnt1);
    end
    checks++;
    if (dut.last !== 1'b0) begin
      failures++;
      $display("FAIL first_last: got %b expected 0", dut.last);
    end
    tick();
  endtask

  task automatic test_write_read();
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i < 2) begin
        req1 = 1'b1; we1 = 1'b1; a1 = 32'h10; wd1 = 32'hDEAD_BEEF; req0 = 1'b0;
      end else begin
        req1 = 1'b0; we1 = 1'b0; req0 = 1'b1; a0 = 32'h10; we0 = 1'b0;
      end
      @(negedge clk);
      predict();
      checks++;
      if ({gnt0, gnt1, mem_we, rd0, rd1, mem_a, mem_wd} !== {e_g0, e_g1, e_we, e_rd0, e_rd1, e_a, e_wd}) begin
        failures++;
        $display("FAIL write_read[%0d]: got g=%b%b we=%b rd0=%h rd1=%h a=%h wd=%h expected g=%b%b we=%b rd0=%h rd1=%h a=%h wd=%h",
                 i, gnt0, gnt1, mem_we, rd0, rd1, mem_a, mem_wd, e_g0, e_g1, e_we, e_rd0, e_rd1, e_a, e_wd);
      end
      if (i == 1) begin
        checks++;
        if ({gnt1, mem_we, mem_a} !== {1'b1, 1'b1, 32'h10}) begin
          failures++;
          $display("FAIL write_grant: got g1=%b we=%b a=%h expected 1 1 00000010", gnt1, mem_we, mem_a);
        end
      end
      if (i == 3) begin
        checks++;
        if ({gnt0, rd0} !== {1'b1, 32'hDEAD_BEEF}) begin
          failures++;
          $display("FAIL readback: got g0=%b rd0=%h expected 1 deadbeef", gnt0, rd0);
        end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int prev = -1, seg = 0, nseg = 0, cur;
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; a0 = 32'h30; a1 = 32'h34;
    for (int i = 0; i < 44; i++) begin
      @(negedge clk);
      predict();
      checks++;
      if ({gnt0, gnt1, mem_we, rd0, rd1, mem_a} !== {e_g0, e_g1, e_we, e_rd0, e_rd1, e_a}) begin
        failures++;
        $display("FAIL b2b_model[%0d]: got g=%b%b a=%h rd0=%h rd1=%h expected g=%b%b a=%h rd0=%h rd1=%h",
                 i, gnt0, gnt1, mem_a, rd0, rd1, e_g0, e_g1, e_a, e_rd0, e_rd1);
      end
      checks++;
      if ((gnt0 ^ gnt1) !== 1'b1) begin
        failures++;
        $display("FAIL b2b_exclusive[%0d]: got g0=%b g1=%b expected exactly one", i, gnt0, gnt1);
      end
      cur = gnt1 ? 1 : 0;
      if (prev >= 0 && cur != prev) begin
        if (nseg > 0) begin
          checks++;
          if (seg != MB) begin
            failures++;
            $display("FAIL burst_len: got %0d expected %0d", seg, MB);
          end
        end
        nseg++;
        seg = 0;
      end
      seg++;
      prev = cur;
      tick();
    end
  endtask

  task automatic test_owner_drop();
    int g1_cycles = 0;
    req0 = 1'b0; req1 = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 15; i++) begin
      req0 = (i != 4);
      req1 = (i >= 1);
      @(negedge clk);
      predict();
      checks++;
      if ({gnt0, gnt1, rd0, rd1, mem_a} !== {e_g0, e_g1, e_rd0, e_rd1, e_a}) begin
        failures++;
        $display("FAIL drop_model[%0d]: got g=%b%b a=%h expected g=%b%b a=%h", i, gnt0, gnt1, mem_a, e_g0, e_g1, e_a);
      end
      if (i == 4) begin
        checks++;
        if ({gnt0, gnt1} !== 2'b00) begin
          failures++;
          $display("FAIL drop_cycle: got g0=%b g1=%b expected 0 0", gnt0, gnt1);
        end
      end
      if (i >= 5) g1_cycles += int'(gnt1);
      tick();
    end
    checks++;
    if (g1_cycles != MB) begin
      failures++;
      $display("FAIL drop_restart: got %0d gnt1 cycles expected %0d", g1_cycles, MB);
    end
  endtask

  task automatic test_mmio();
    req0 = 1'b0; req1 = 1'b0;
    tick();
    sw = 8'h5A; req0 = 1'b1; we0 = 1'b0; a0 = MMIO_SWITCHES;
    tick();
    @(negedge clk);
    predict();
    checks++;
    if ({gnt0, rd0, rd1} !== {e_g0, e_rd0, e_rd1}) begin
      failures++;
      $display("FAIL mmio_model: got g0=%b rd0=%h rd1=%h expected g0=%b rd0=%h rd1=%h", gnt0, rd0, rd1, e_g0, e_rd0, e_rd1);
    end
    checks++;
    if ({gnt0, rd0, rd1} !== {1'b1, 32'h0000_005A, 32'h0}) begin
      failures++;
      $display("FAIL mmio_switches: got g0=%b rd0=%h rd1=%h expected 1 0000005a 0", gnt0, rd0, rd1);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    v = $urandom;
    req0 = 1'b0; req1 = 1'b0;
    tick();
    req1 = 1'b1; we1 = 1'b1; a1 = 32'h40; wd1 = 32'h1234_5678;
    tick();
    tick();
    a1 = 32'h44; wd1 = v; reset = 1'b1;
    @(negedge clk);
    predict();
    checks++;
    if ({gnt1, mem_we, mem_a, mem_wd} !== {e_g1, e_we, e_a, e_wd}) begin
      failures++;
      $display("FAIL reset_mid_write: got g1=%b we=%b a=%h wd=%h expected g1=%b we=%b a=%h wd=%h",
               gnt1, mem_we, mem_a, mem_wd, e_g1, e_we, e_a, e_wd);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({gnt0, gnt1, {stat_gnt0, stat_gnt1, stat_wait1}} !== {2'b00, 48'h0}) begin
      failures++;
      $display("FAIL reset_mid_idle: got g0=%b g1=%b stats=%h/%h/%h expected 0 0 0",
               gnt0, gnt1, stat_gnt0, stat_gnt1, stat_wait1);
    end
    reset = 1'b0; req1 = 1'b0; we1 = 1'b0; req0 = 1'b1; we0 = 1'b0; a0 = 32'h44;
    tick();
    @(negedge clk);
    predict();
    checks++;
    if ({gnt0, rd0} !== {1'b1, v}) begin
      failures++;
      $display("FAIL reset_mid_commit: got g0=%b rd0=%h expected 1 %h", gnt0, rd0, v);
    end
    checks++;
    if (rd0 !== e_rd0) begin
      failures++;
      $display("FAIL reset_mid_model: got rd0=%h expected %h", rd0, e_rd0);
    end
    tick();
  endtask

  task automatic test_random();
    bit pend0 = 1'b0, pend1 = 1'b0;
    logic [15:0] x0, x1, x2;
    for (int i = 0; i < 500; i++) begin
      if (!pend0) begin
        req0 = ($urandom_range(0, 3) != 0);
        we0  = $urandom_range(0, 1) == 1;
        wd0  = $urandom;
        a0   = ($urandom_range(0, 7) == 0) ? MMIO_SWITCHES : {22'h0, 8'($urandom_range(0, 63)), 2'b00};
      end
      if (!pend1) begin
        req1 = ($urandom_range(0, 2) != 0);
        we1  = $urandom_range(0, 1) == 1;
        wd1  = $urandom;
        a1   = ($urandom_range(0, 7) == 0) ? MMIO_SWITCHES : {22'h0, 8'($urandom_range(0, 63)), 2'b00};
      end
      if ($urandom_range(0, 15) == 0) sw = 8'($urandom);
      @(negedge clk);
      predict();
      checks++;
      if ({gnt0, gnt1, mem_we, rd0, rd1, mem_a, mem_wd} !== {e_g0, e_g1, e_we, e_rd0, e_rd1, e_a, e_wd}) begin
        failures++;
        $display("FAIL random[%0d]: got g=%b%b we=%b rd0=%h rd1=%h a=%h wd=%h expected g=%b%b we=%b rd0=%h rd1=%h a=%h wd=%h",
                 i, gnt0, gnt1, mem_we, rd0, rd1, mem_a, mem_wd, e_g0, e_g1, e_we, e_rd0, e_rd1, e_a, e_wd);
      end
      pend0 = req0 && !e_g0;
      pend1 = req1 && !e_g1;
      tick();
    end
    @(negedge clk);
`ifdef ARB_STATS_EN
    x0 = 16'(m_sg0); x1 = 16'(m_sg1); x2 = 16'(m_sw1);
`else
    x0 = 16'h0; x1 = 16'h0; x2 = 16'h0;
`endif
    checks++;
    if ({stat_gnt0, stat_gnt1, stat_wait1} !== {x0, x1, x2}) begin
      failures++;
      $display("FAIL stats: got %0d/%0d/%0d expected %0d/%0d/%0d", stat_gnt0, stat_gnt1, stat_wait1, x0, x1, x2);
    end
  endtask

  initial begin
    reset = 1'b1; sw = 8'h00;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    a0 = '0; a1 = '0; wd0 = '0; wd1 = '0;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_owner_drop();
    test_mmio();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
